serial_adder: RTL and testbench

- Bit-serial adder: one `WIDTH`-bit sum per operation, one bit per clock, LSB first.
- Each cycle it feeds one operand bit pair and the registered carry into a single `FULL_ADDER`, then captures `S` and `CO`.
- It is the small-area alternative to the ripple-carry adder chain.
- It sits beside the ALU as a multi-cycle arithmetic unit driven by a start/done handshake.

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/serial_adder_full_adder.sv | 13 +
 rtl/serial_adder.sv | 161 ++++++++++++++++
 tb/tb_serial_adder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: default width and FSM encoding.
// Optional subtraction is enabled by defining SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder; the only arithmetic element of the serial datapath.
module serial_adder_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, one bit per clock, start/done handshake.
// Define SERIAL_ADDER_SUB_EN to add the SUB port (A - B as A + ~B + 1).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             SUB,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] R,
  output logic             CO,
  output logic             OVF
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sr_q,   a_sr_d;
  logic [WIDTH-1:0] b_sr_q,   b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] r_q,      r_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             carry_q,  carry_d;
  logic             co_q,     co_d;
  logic             ovf_q,    ovf_d;

  logic accept;
  logic last_bit;
  logic fa_b;
  logic fa_s;
  logic fa_co;
  logic carry_preset;

  assign accept   = (state_q == ST_IDLE) && START;
  assign last_bit = (cnt_q == LAST_BIT);

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q, sub_d;

  assign fa_b         = b_sr_q[0] ^ sub_q;
  assign carry_preset = SUB;
`else
  assign fa_b         = b_sr_q[0];
  assign carry_preset = 1'b0;
`endif

  serial_adder_full_adder u_fa (
    .a  (a_sr_q[0]),
    .b  (fa_b),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // FSM: state register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    // NOTE: default assignment first so no path through the block infers a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (START)    state_d = ST_RUN;
      ST_RUN:  if (last_bit) state_d = ST_DONE;
      ST_DONE:               state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // FSM: Moore outputs
  always_comb begin
    BUSY = (state_q == ST_RUN) || (state_q == ST_DONE);
    DONE = (state_q == ST_DONE);
  end

  // Datapath: operand/sum shifting, carry, counter and completion capture
  always_comb begin
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    co_d     = co_q;
    ovf_d    = ovf_q;
`ifdef SERIAL_ADDER_SUB_EN
    sub_d    = sub_q;
`endif
    if (accept) begin
      a_sr_d  = A;
      b_sr_d  = B;
      carry_d = carry_preset;
      cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_d   = SUB;
`endif
    end else if (state_q == ST_RUN) begin
      a_sr_d   = a_sr_q >> 1;
      b_sr_d   = b_sr_q >> 1;
      sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
      carry_d  = fa_co;
      if (last_bit) begin
        // carry_q is the carry into the MSB here, fa_co the carry out of it
        r_d   = {fa_s, sum_sr_q[WIDTH-1:1]};
        co_d  = fa_co;
        ovf_d = carry_q ^ fa_co;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      r_q      <= '0;
      co_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      co_q     <= co_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef SERIAL_ADDER_SUB_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sub_q <= 1'b0;
    else     sub_q <= sub_d;
  end
`endif

  assign R   = r_q;
  assign CO  = co_q;
  assign OVF = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=32).
// Subtraction vectors are used when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

  localparam int WIDTH = 32;

  logic             CLK = 1'b0;
  logic             RST;
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] R;
  logic             CO;
  logic             OVF;
`ifdef SERIAL_ADDER_SUB_EN
  logic             SUB;
`endif

  int n_vec = 0;
  int n_err = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
`ifdef SERIAL_ADDER_SUB_EN
    .SUB   (SUB),
`endif
    .BUSY  (BUSY),
    .DONE  (DONE),
    .R     (R),
    .CO    (CO),
    .OVF   (OVF)
  );

  always #5 CLK = ~CLK;

  // Inputs are driven and outputs sampled on the falling edge.
  // lat = number of rising edges after the accepting edge until DONE is seen.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       output int lat);
    @(negedge CLK);
    A = a; B = b; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    lat = 0;
    while (DONE !== 1'b1 && lat < WIDTH + 8) begin
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; A = '0; B = '0;
`ifdef SERIAL_ADDER_SUB_EN
    SUB = 1'b0;
`endif
    repeat (2) @(negedge CLK);
    n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    n_vec++; if (DONE !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", DONE); end
    n_vec++; if (R !== '0) begin n_err++; $display("FAIL reset_r: got %h want 0", R); end
    n_vec++; if (CO !== 1'b0) begin n_err++; $display("FAIL reset_co: got %b want 0", CO); end
    n_vec++; if (OVF !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", OVF); end
    RST = 1'b0;
  endtask

  task automatic test_add_basic();
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at  = -1;
    @(negedge CLK);
    A = 32'd5; B = 32'd3; START = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      START = 1'b0;
      if (BUSY === 1'b1) busy_cnt++;
      if (DONE === 1'b1) begin done_cnt++; done_at = i; end
    end
    n_vec++; if (R !== 32'd8) begin n_err++; $display("FAIL add_basic_r: got %h want %h", R, 32'd8); end
    n_vec++; if (CO !== 1'b0 || OVF !== 1'b0) begin n_err++; $display("FAIL add_basic_flags: got co=%b ovf=%b want co=0 ovf=0", CO, OVF); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL add_basic_done_count: got %0d want 1", done_cnt); end
    n_vec++; if (done_at !== WIDTH) begin n_err++; $display("FAIL add_basic_done_edge: got %0d want %0d", done_at, WIDTH); end
    n_vec++; if (busy_cnt !== WIDTH + 1) begin n_err++; $display("FAIL add_basic_busy_cycles: got %0d want %0d", busy_cnt, WIDTH + 1); end
  endtask

  task automatic test_carry_overflow();
    int lat;
    do_op(32'hFFFF_FFFF, 32'h0000_0001, lat);
    n_vec++; if (lat !== WIDTH) begin n_err++; $display("FAIL wrap_latency: got %0d want %0d", lat, WIDTH); end
    n_vec++; if (R !== 32'h0000_0000 || CO !== 1'b1 || OVF !== 1'b0) begin n_err++; $display("FAIL wrap_result: got r=%h co=%b ovf=%b want r=00000000 co=1 ovf=0", R, CO, OVF); end
    do_op(32'h7FFF_FFFF, 32'h0000_0001, lat);
    n_vec++; if (R !== 32'h8000_0000 || CO !== 1'b0 || OVF !== 1'b1) begin n_err++; $display("FAIL pos_ovf: got r=%h co=%b ovf=%b want r=80000000 co=0 ovf=1", R, CO, OVF); end
    do_op(32'h8000_0000, 32'h8000_0000, lat);
    n_vec++; if (R !== 32'h0000_0000 || CO !== 1'b1 || OVF !== 1'b1) begin n_err++; $display("FAIL neg_ovf: got r=%h co=%b ovf=%b want r=00000000 co=1 ovf=1", R, CO, OVF); end
  endtask

  task automatic test_sub();
    int lat;
`ifdef SERIAL_ADDER_SUB_EN
    SUB = 1'b1;
    do_op(32'd3, 32'd5, lat);
    n_vec++; if (R !== 32'hFFFF_FFFE || CO !== 1'b0 || OVF !== 1'b0) begin n_err++; $display("FAIL sub_borrow: got r=%h co=%b ovf=%b want r=fffffffe co=0 ovf=0", R, CO, OVF); end
    do_op(32'h8000_0000, 32'd1, lat);
    n_vec++; if (R !== 32'h7FFF_FFFF || CO !== 1'b1 || OVF !== 1'b1) begin n_err++; $display("FAIL sub_ovf: got r=%h co=%b ovf=%b want r=7fffffff co=1 ovf=1", R, CO, OVF); end
    SUB = 1'b0;
    do_op(32'd3, 32'd5, lat);
    n_vec++; if (R !== 32'd8) begin n_err++; $display("FAIL sub_off_add: got %h want %h", R, 32'd8); end
`else
    do_op(32'd3, 32'd5, lat);
    n_vec++; if (R !== 32'd8 || CO !== 1'b0 || OVF !== 1'b0) begin n_err++; $display("FAIL add_only: got r=%h co=%b ovf=%b want r=00000008 co=0 ovf=0", R, CO, OVF); end
`endif
  endtask

  task automatic test_start_ignored();
    int done_cnt = 0;
    int done_at  = -1;
    @(negedge CLK);
    A = 32'd10; B = 32'd20; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge CLK);
      if (i == 10) begin A = 32'd1; B = 32'd1; START = 1'b1; end
      if (i == 11) START = 1'b0;
      if (DONE === 1'b1) begin done_cnt++; done_at = i; end
    end
    n_vec++; if (R !== 32'd30) begin n_err++; $display("FAIL ignored_r: got %h want %h", R, 32'd30); end
    n_vec++; if (done_cnt !== 1 || done_at !== WIDTH) begin n_err++; $display("FAIL ignored_done: got count=%0d edge=%0d want count=1 edge=%0d", done_cnt, done_at, WIDTH); end
    n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL ignored_not_queued: got busy=%b want 0", BUSY); end
  endtask

  task automatic test_back_to_back();
    int done1 = -1;
    int done2 = -1;
    int r_bad = 0;
    logic busy33 = 1'bx;
    logic busy34 = 1'bx;
    @(negedge CLK);
    A = 32'd1; B = 32'd2; START = 1'b1;
    for (int i = 0; i < 75; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) begin
        if (done1 < 0) done1 = i; else done2 = i;
      end
      if (i == WIDTH) begin A = 32'd7; B = 32'd8; end
      if (i == WIDTH + 1) busy33 = BUSY;
      if (i == WIDTH + 2) begin busy34 = BUSY; START = 1'b0; end
      if (i >= WIDTH && i < 2 * WIDTH + 2 && R !== 32'd3) r_bad++;
    end
    n_vec++; if (done1 !== WIDTH) begin n_err++; $display("FAIL b2b_done1: got %0d want %0d", done1, WIDTH); end
    n_vec++; if (busy33 !== 1'b0 || busy34 !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got busy33=%b busy34=%b want 0 1", busy33, busy34); end
    n_vec++; if (r_bad !== 0) begin n_err++; $display("FAIL b2b_r_stable: got %0d unstable cycles want 0", r_bad); end
    n_vec++; if (done2 !== 2 * WIDTH + 2) begin n_err++; $display("FAIL b2b_done2: got %0d want %0d", done2, 2 * WIDTH + 2); end
    n_vec++; if (R !== 32'd15) begin n_err++; $display("FAIL b2b_r2: got %h want %h", R, 32'd15); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int done_seen = 0;
    @(negedge CLK);
    A = 32'h1234_5678; B = 32'd1; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (12) @(negedge CLK);
    RST = 1'b1;
    #1;
    n_vec++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin n_err++; $display("FAIL midrst_ctrl: got busy=%b done=%b want 0 0", BUSY, DONE); end
    n_vec++; if (R !== '0 || CO !== 1'b0 || OVF !== 1'b0) begin n_err++; $display("FAIL midrst_data: got r=%h co=%b ovf=%b want 0 0 0", R, CO, OVF); end
    A = 32'd100; B = 32'd23; START = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      if (DONE !== 1'b0 || BUSY !== 1'b0) done_seen++;
    end
    n_vec++; if (done_seen !== 0) begin n_err++; $display("FAIL midrst_hold: got %0d active cycles want 0", done_seen); end
    RST = 1'b0;
    @(negedge CLK);
    n_vec++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL midrst_first_accept: got busy=%b want 1", BUSY); end
    START = 1'b0;
    lat = 0;
    while (DONE !== 1'b1 && lat < WIDTH + 8) begin
      @(negedge CLK);
      lat++;
    end
    n_vec++; if (lat !== WIDTH) begin n_err++; $display("FAIL midrst_latency: got %0d want %0d", lat, WIDTH); end
    n_vec++; if (R !== 32'd123) begin n_err++; $display("FAIL midrst_result: got %h want %h", R, 32'd123); end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_carry_overflow();
    test_sub();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
